lstm_net_cell: RTL and testbench

Single fixed-point LSTM cell that performs one recurrent time step per clock on an 8-bit input sample.
- Gate weights come from an 8-bank constant weight ROM selected per sample by `add`.
- Produces hidden state `Hout`, a registered copy of the bank address `Add`, and an end-of-frame strobe `Of`. Eight samples (banks 0..7) form one frame.
- Sits after the audio feature front end; feeds the downstream classifier.

---
 rtl/lstm_pkg.sv | 52 +++++
 rtl/lstm_net_cell_gate.sv | 32 +++
 rtl/lstm_net_cell.sv | 69 ++++++
 tb/tb_lstm_net_cell.sv | 137 +++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Fixed-point widths, weight-bank layout, constant weight ROM and the
// hard activation functions shared by the LSTM cell.
package lstm_pkg;
  localparam int unsigned NUM_BANKS = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned W_W       = 8;
  localparam int unsigned Z_W       = 20;
  localparam int unsigned ACT_W     = 10;
  localparam int unsigned C_W       = 10;

  typedef enum logic {ACT_SIGMOID, ACT_TANH} act_t;

  typedef struct packed {
    logic signed [W_W-1:0] wx;
    logic signed [W_W-1:0] wh;
    logic signed [W_W-1:0] b;
  } gate_w_t;

  typedef struct packed {
    gate_w_t i;
    gate_w_t f;
    gate_w_t o;
    gate_w_t g;
  } bank_t;

  localparam gate_w_t DEF_GATE = '{wx: 8'sd64, wh: 8'sd0, b: 8'sd0};
  localparam bank_t   DEF_BANK = '{i: DEF_GATE, f: DEF_GATE, o: DEF_GATE, g: DEF_GATE};
  localparam bank_t   WEIGHT_ROM [NUM_BANKS] = '{default: DEF_BANK};

  function automatic logic signed [7:0] sat8(input logic signed [Z_W-1:0] v);
    logic signed [7:0] r;
    if (v < -20'sd128)      r = -8'sd128;
    else if (v > 20'sd127)  r = 8'sd127;
    else                    r = v[7:0];
    return r;
  endfunction

  // 0..256 where 256 represents 1.0
  function automatic logic [8:0] hard_sigmoid(input logic signed [Z_W-1:0] z);
    logic signed [Z_W-1:0] s;
    logic [8:0]            r;
    s = (z >>> 8) + 20'sd128;
    if (s < 20'sd0)        r = '0;
    else if (s > 20'sd256) r = 9'd256;
    else                   r = s[8:0];
    return r;
  endfunction

  function automatic logic signed [7:0] hard_tanh(input logic signed [Z_W-1:0] z);
    return sat8(z >>> 7);
  endfunction
endpackage

// File: rtl/lstm_net_cell_gate.sv
// One LSTM gate: exact Q.14 pre-activation followed by a hard sigmoid or tanh.
module lstm_gate
  import lstm_pkg::*;
#(
  parameter act_t ACT = ACT_SIGMOID
) (
  input  logic        [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_h,
  input  gate_w_t                  i_w,
  output logic signed [ACT_W-1:0]  o_act
);
  logic signed [Z_W-1:0] w_xt;
  logic signed [Z_W-1:0] w_ht;
  logic signed [Z_W-1:0] w_bt;
  logic signed [Z_W-1:0] w_z;

  // all terms aligned to Q.14: x is Q0.8 * Q2.6, h is Q1.7 * Q2.6 (<<1), b is Q1.7 (<<7)
  always_comb begin
    w_xt = Z_W'($signed(i_w.wx)) * $signed(Z_W'(i_x));
    w_ht = (Z_W'($signed(i_w.wh)) * Z_W'(i_h)) <<< 1;
    w_bt = Z_W'($signed(i_w.b)) <<< 7;
    w_z  = w_xt + w_ht + w_bt;
  end

  generate
    if (ACT == ACT_TANH) begin : g_tanh
      assign o_act = ACT_W'(hard_tanh(w_z));
    end else begin : g_sigm
      assign o_act = ACT_W'(hard_sigmoid(w_z));
    end
  endgenerate
endmodule

// File: rtl/lstm_net_cell.sv
// Single-step fixed-point LSTM cell: bank-selected weights, c/h state,
// registered bank address and end-of-frame strobe.
module lstm_net_cell
  import lstm_pkg::*;
(
  input  logic              clk,
  input  logic              cen,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] add,
  input  logic              Cip,
  output logic [DATA_W-1:0] Hout,
  output logic [DATA_W-1:0] Add,
  output logic              Of
);
  logic signed [C_W-1:0]    r_c;
  logic signed [DATA_W-1:0] r_h;
  logic [DATA_W-1:0]        r_add;
  logic                     r_of;

  bank_t                    w_bank;
  logic signed [ACT_W-1:0]  w_i, w_f, w_o, w_g;
  logic signed [Z_W-1:0]    w_fc, w_ig, w_csum, w_oh;
  logic signed [C_W-1:0]    w_cnew;
  logic signed [7:0]        w_cclip;
  logic signed [DATA_W-1:0] w_hnew;

  assign w_bank = WEIGHT_ROM[add[2:0]];

  lstm_gate #(.ACT(ACT_SIGMOID)) u_gate_i (.i_x(in), .i_h(r_h), .i_w(w_bank.i), .o_act(w_i));
  lstm_gate #(.ACT(ACT_SIGMOID)) u_gate_f (.i_x(in), .i_h(r_h), .i_w(w_bank.f), .o_act(w_f));
  lstm_gate #(.ACT(ACT_SIGMOID)) u_gate_o (.i_x(in), .i_h(r_h), .i_w(w_bank.o), .o_act(w_o));
  lstm_gate #(.ACT(ACT_TANH))    u_gate_g (.i_x(in), .i_h(r_h), .i_w(w_bank.g), .o_act(w_g));

  always_comb begin
    w_fc   = Z_W'(w_f) * Z_W'(r_c);
    w_ig   = Z_W'(w_i) * Z_W'(w_g);
    w_csum = (w_fc >>> 8) + (w_ig >>> 8);
    if (w_csum > 20'sd511)       w_cnew = 10'sd511;
    else if (w_csum < -20'sd512) w_cnew = -10'sd512;
    else                         w_cnew = w_csum[C_W-1:0];
    w_cclip = sat8(Z_W'(w_cnew));
    w_oh    = Z_W'(w_o) * Z_W'(w_cclip);
    // range is inherently within Q1.7; saturation only reads the full product
    w_hnew  = sat8(w_oh >>> 8);
  end

  always_ff @(posedge clk or negedge cen) begin
    if (!cen) begin
      r_c   <= '0;
      r_h   <= '0;
      r_add <= '0;
      r_of  <= 1'b0;
    end else begin
      r_add <= add;
      r_of  <= (add[2:0] == 3'd7);
      if (Cip) begin
        r_c <= '0;
        r_h <= '0;
      end else begin
        r_c <= w_cnew;
        r_h <= w_hnew;
      end
    end
  end

  assign Hout = r_h;
  assign Add  = r_add;
  assign Of   = r_of;
endmodule

// File: tb/tb_lstm_net_cell.sv
// Scoreboard bench for lstm_net_cell: driver queues hand-computed results,
// monitor pops and compares one cycle later.
module tb_lstm_net_cell;
  logic       clk;
  logic       cen;
  logic       Cip;
  logic [7:0] in_s;
  logic [7:0] add_s;
  logic [7:0] Hout;
  logic [7:0] Add;
  logic       Of;

  typedef struct {
    int    h;
    int    a;
    int    o;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  lstm_net_cell dut (
    .clk (clk),
    .cen (cen),
    .in  (in_s),
    .add (add_s),
    .Cip (Cip),
    .Hout(Hout),
    .Add (Add),
    .Of  (Of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic issue(input int x, input int a, input int clr, input int eh, input int eo,
                       input string tag);
    exp_t e;
    @(negedge clk);
    in_s  = x[7:0];
    add_s = a[7:0];
    Cip   = clr[0];
    e.h = eh; e.a = a; e.o = eo; e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cen && q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".Hout"}, int'($signed(Hout)), e.h);
        chk({e.tag, ".Add"},  int'(Add),           e.a);
        chk({e.tag, ".Of"},   int'(Of),            e.o);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    Cip   = 1'b0;
    in_s  = 8'($urandom);
    add_s = 8'($urandom);
    cen   = 1'b1;
    #1 cen = 1'b0;
    #1;
    chk("rst_async.Hout", int'(Hout), 0);
    chk("rst_async.Add",  int'(Add),  0);
    chk("rst_async.Of",   int'(Of),   0);
    add_s = 8'hFF;
    @(posedge clk); #1;
    chk("rst_held.Add", int'(Add), 0);
    chk("rst_held.Of",  int'(Of),  0);

    in_s = '0; add_s = '0;
    @(posedge clk); #2 cen = 1'b1;

    issue(0,   0, 0,  0, 0, "zero");
    issue(128, 0, 0, 25, 0, "step1");
    issue(128, 1, 0, 40, 0, "step2");
    issue(128, 2, 1,  0, 0, "clear");
    issue(128, 3, 0, 25, 0, "after_clear");
    issue(0,   4, 1,  0, 0, "clear2");
    issue(255, 5, 0, 70, 0, "full_in");
    issue(0,   6, 0, 23, 0, "decay1");
    issue(0,   7, 0, 11, 1, "decay2");

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++)
        issue(0, (r << 3) | k, (r == 0 && k == 0) ? 1 : 0, 0, (k == 7) ? 1 : 0, "frame");
    issue(0, 7,  0, 0, 1, "of_b2b_a");
    issue(0, 15, 0, 0, 1, "of_b2b_b");
    issue(0, 8,  0, 0, 0, "of_b2b_end");

    issue(128, 0, 0, 25, 0, "build0");
    issue(128, 1, 0, 40, 0, "build1");
    issue(128, 2, 0, 50, 0, "build2");
    issue(128, 3, 0, 56, 0, "build3");

    @(negedge clk);
    in_s = 8'd128; add_s = 8'd4; Cip = 1'b0;
    #2 cen = 1'b0;
    #1;
    chk("rst_mid.Hout", int'(Hout), 0);
    chk("rst_mid.Add",  int'(Add),  0);
    chk("rst_mid.Of",   int'(Of),   0);
    @(posedge clk); #1;
    chk("rst_mid_held.Hout", int'(Hout), 0);
    #1 cen = 1'b1;
    issue(128, 4, 0, 25, 0, "post_rst1");
    issue(128, 5, 0, 40, 0, "post_rst2");

    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    @(posedge clk); #2;
    if (q.size() != 0) chk("drain.pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
